// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed N-tap FIR with one shared 16x16 MAC, one tap per clock.
// Samples arrive over valid/ready; coefficients are runtime-loadable while the engine is idle.
// Optional feature macro: FIR_SAT_EN (clamp the shifted result to the DW-bit signed range;
// when undefined the result wraps to its low DW bits).
module fir_mac_sequencer #(
  parameter int unsigned TAPS = 57,
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = 14,
  parameter int unsigned AW   = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic signed [DW-1:0] in_data_i,
  output logic                 out_valid_o,
  output logic signed [DW-1:0] out_data_o,
  input  logic                 coef_we_i,
  input  logic [AW-1:0]        coef_addr_i,
  input  logic signed [DW-1:0] coef_data_i,
  output logic                 busy_o
);

  localparam int unsigned AccW = 2 * DW + AW;
  localparam logic [AW-1:0] LastIdx = AW'(TAPS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StMac, StOut} state_e;

  state_e               state_q;
  logic signed [DW-1:0] coef_q [TAPS];
  logic signed [DW-1:0] x_q    [TAPS];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW-1:0]        k_q;
  logic signed [DW-1:0] sample_q;
  logic signed [AccW-1:0] acc_q;
  logic                 out_valid_q;
  logic signed [DW-1:0] out_data_q;

  logic signed [2*DW-1:0] prod;
  logic signed [AccW-1:0] prod_ext;
  logic signed [DW-1:0]   out_conv;
  logic                   coef_wr_en;

  // Handshake outputs are decoded straight from the state register.
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    out_valid_o = out_valid_q;
    out_data_o  = out_data_q;
  end

  // Coefficient writes land only in IDLE and only for in-range tap indices.
  always_comb begin
    coef_wr_en = coef_we_i && (state_q == StIdle) && (32'(coef_addr_i) < TAPS);
  end

  // Full-precision product of the current tap, sign-extended to accumulator width.
  always_comb begin
    prod     = x_q[rd_ptr_q] * coef_q[k_q];
    prod_ext = {{AW{prod[2*DW-1]}}, prod};
  end

`ifdef FIR_SAT_EN
  localparam int unsigned ShW = AccW - FRAC;
  localparam logic signed [ShW-1:0] SatMax = {{(ShW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ShW-1:0] SatMin = {{(ShW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};
  logic signed [ShW-1:0] shifted;

  // Arithmetic shift then clamp into the signed DW-bit range.
  always_comb begin
    shifted = ShW'(acc_q >>> FRAC);
    if (shifted > SatMax) begin
      out_conv = {1'b0, {(DW - 1){1'b1}}};
    end else if (shifted < SatMin) begin
      out_conv = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      out_conv = shifted[DW-1:0];
    end
  end
`else
  // Arithmetic shift keeping only the low DW bits (two's-complement wrap).
  always_comb begin
    out_conv = acc_q[FRAC +: DW];
  end
`endif

  // Coefficient file, cleared on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_wr_en) begin
      coef_q[coef_addr_i] <= coef_data_i;
    end
  end

  // Circular sample history; the latched sample is committed during LOAD.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        x_q[i] <= '0;
      end
    end else if (state_q == StLoad) begin
      x_q[wr_ptr_q] <= sample_q;
    end
  end

  // Sequencer FSM with its datapath registers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      k_q         <= '0;
      sample_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            sample_q <= in_data_i;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          acc_q    <= '0;
          k_q      <= '0;
          rd_ptr_q <= wr_ptr_q;
          state_q  <= StMac;
        end
        StMac: begin
          acc_q <= acc_q + prod_ext;
          k_q   <= k_q + AW'(1);
          // Read pointer walks backwards through history, wrapping below zero.
          rd_ptr_q <= (rd_ptr_q == '0) ? LastIdx : rd_ptr_q - AW'(1);
          if (k_q == LastIdx) begin
            state_q <= StOut;
          end
        end
        StOut: begin
          out_data_q  <= out_conv;
          out_valid_q <= 1'b1;
          wr_ptr_q    <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + AW'(1);
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR engine for the waveform generator's reconstruction/low-pass stage. It computes an N-tap FIR with a single shared 16×16 multiplier-accumulator, sequencing one tap per clock. It sits between the waveform sample source (valid/ready) and the DAC output path. Coefficients are runtime-loadable, so one block serves every filter profile.

## Interface
- TAPS, 57, number of filter taps (2..64)
- DW, 16, sample and coefficient width, signed two's complement
- FRAC, 14, coefficient fraction bits (Q1.14); output = acc >>> FRAC
- AW, 6, tap address width, ≥ ceil(log2(TAPS))

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DW  signed input sample
- out_valid  out  1  one-cycle pulse, out_data valid
- out_data  out  DW  signed filtered sample, held until next out_valid
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  coefficient index k
- coef_data  in  DW  signed coefficient value
- busy  out  1  high in any state other than IDLE

## Operation
- Storage: coefficient file coef[0..TAPS-1]; circular sample buffer x[0..TAPS-1]; write pointer wr_ptr (0..TAPS-1); accumulator acc, width 2·DW+AW (38 bits at defaults), signed.
- FSM states:
  - IDLE: in_ready=1. in_valid=1 latches in_data and goes to LOAD.
  - LOAD: writes the sample to x[wr_ptr]; clears acc; sets k=0; goes to MAC.
  - MAC: acc += x[(wr_ptr−k) mod TAPS] · coef[k]. After TAPS iterations (k=TAPS−1), goes to OUT.
  - OUT: registers out_data from acc >>> FRAC; pulses out_valid; wr_ptr ← (wr_ptr+1) mod TAPS; goes to IDLE.
- Index wrap: if wr_ptr−k < 0, add TAPS. Never index ≥ TAPS.
- Products are full signed 2·DW bits, sign-extended into acc. No intermediate rounding or truncation.
- Output conversion is an arithmetic right shift (truncation toward −∞). Narrowing to DW bits is controlled by Configuration.
- Coefficient writes:
  - Accepted only when the FSM is in IDLE, by coef[coef_addr] ← coef_data on that edge.
  - Writes when busy=1, or with coef_addr ≥ TAPS, are dropped silently.
  - A write and an input accept on the same IDLE cycle are both taken. The new coefficient applies to that sample.
- Reset drives:
  - state IDLE, wr_ptr 0, acc 0
  - all x[] and coef[] to 0
  - out_valid 0, out_data 0
  - in_ready 1 on the first clock after rst deasserts
- Reset mid-operation aborts the sample in flight. No out_valid is produced for it.

## Timing
- Accept edge = cycle 0 (in_valid & in_ready).
- LOAD occupies cycle 1. MAC occupies cycles 2..TAPS+1. out_valid is high during cycle TAPS+2 (59 at defaults), for exactly one cycle.
- in_ready is high only in IDLE. Throughput is one sample per TAPS+3 cycles (60) with in_valid held high.
- out_data changes only on the out_valid edge.
- busy = !in_ready.

## Configuration
- FIR_SAT_EN defined: the shifted result is clamped to [−2^(DW−1), 2^(DW−1)−1] (−32768..32767).
- FIR_SAT_EN undefined: out_data is the low DW bits of the shifted result (two's-complement wrap).
- All other behaviour is identical.

## Test plan
- **Impulse response:** coef[k]=k+1 for k=0..56. Feed 16384, then 60 zeros. Outputs are 1,2,…,57, then 0 thereafter.
- **Passthrough and latency:** coef[0]=16384, others 0. Feed 100, −200, 32767. Outputs are 100, −200, 32767, each with out_valid exactly 59 cycles after its accept edge.
- **Saturation:** all coef=16384. Feed 32767 twice; the second output's shifted value is 65534.
  - FIR_SAT_EN defined: out_data=32767.
  - FIR_SAT_EN undefined: out_data=−2.
  - Repeat with −32768 twice: −32768 with the macro, 0 without.
- **Handshake and wrap:** in_valid held high for 200 samples. in_ready and out_valid each pulse once per 60 cycles. wr_ptr wraps 56→0 with no glitch in the impulse-response check.
- **Coefficient write gating:** coef[0]=16384. Write coef[0]=100 during MAC; the next sample 1000 outputs 1000 (write dropped). Write coef[0]=100 in IDLE together with sample 16384; output is 100.
- **Reset mid-MAC:** assert rst at cycle 20 after accept. No out_valid is produced. out_data=0, in_ready=1 after release. A subsequent impulse with coef[0]=16384 returns 16384.
